// File: rtl/aes_gf_pkg.sv
// Shared GF(2^8) helpers and mode encodings for the AES round datapath.
package aes_gf_pkg;

  localparam logic [7:0] GF_POLY  = 8'h1b;
  localparam logic [1:0] MODE_BYP = 2'b00;
  localparam logic [1:0] MODE_FWD = 2'b01;
  localparam logic [1:0] MODE_INV = 2'b10;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  // Shift-and-add multiply by an arbitrary constant.
  function automatic logic [7:0] gf_mul_const(input logic [7:0] b, input logic [7:0] c);
    logic [7:0] acc;
    logic [7:0] p;
    logic [7:0] cc;
    acc = '0;
    p   = b;
    cc  = c;
    for (int i = 0; i < 8; i++) begin
      if (cc[0]) acc = acc ^ p;
      p  = xtime(p);
      cc = cc >> 1;
    end
    return acc;
  endfunction

endpackage

// File: rtl/gf_mixcol_col.sv
// One state column of (Inv)MixColumns, built from precomputed 1x/2x/4x/8x byte multiples.
module gf_mixcol_col
  import aes_gf_pkg::*;
(
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic [31:0] x4,
  input  logic [31:0] x8,
  input  logic [1:0]  mode,
  output logic [31:0] res
);

  logic [31:0] fwd, inv;
  logic [31:0] m3, m9, mb, md, me;

  assign m3 = x2 ^ x1;
  assign m9 = x8 ^ x1;
  assign mb = x8 ^ x2 ^ x1;
  assign md = x8 ^ x4 ^ x1;
  assign me = x8 ^ x4 ^ x2;

  // Rotating a column left by one byte lines row i up with a_(i+1), two bytes with a_(i+2), etc.
  assign fwd = x2 ^ {m3[23:0], m3[31:24]} ^ {x1[15:0], x1[31:16]} ^ {x1[7:0], x1[31:8]};
  assign inv = me ^ {mb[23:0], mb[31:24]} ^ {md[15:0], md[31:16]} ^ {m9[7:0], m9[31:8]};

  always_comb begin
    res = x1;
    case (mode)
      MODE_FWD: res = fwd;
      MODE_INV: res = inv;
      default:  res = x1;
    endcase
  end

endmodule

// File: rtl/gf_mixcol_pipe.sv
// Elastic (Inv)MixColumns pipeline: NUM_COLS columns per beat, 1 or 2 register stages.
module gf_mixcol_pipe
  import aes_gf_pkg::*;
#(
  parameter int unsigned NUM_COLS   = 4,
  parameter int unsigned PIPE_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_mode,
  input  logic [32*NUM_COLS-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_mode,
  output logic [32*NUM_COLS-1:0]  out_data
);

  localparam int unsigned W  = 32 * NUM_COLS;
  localparam int unsigned NB = 4 * NUM_COLS;

  logic [W-1:0] x2_in, x4_in, x8_in;

  for (genvar k = 0; k < NB; k++) begin : g_byte
    assign x2_in[8*k +: 8] = xtime(in_data[8*k +: 8]);
    assign x4_in[8*k +: 8] = xtime(x2_in[8*k +: 8]);
    assign x8_in[8*k +: 8] = xtime(x4_in[8*k +: 8]);
  end

  logic [W-1:0] s1_x1, s1_x2, s1_x4, s1_x8;
  logic [1:0]   s1_mode;
  logic         s1_valid;
  logic         out_load;
  logic [W-1:0] res;

  assign out_load = !out_valid || out_ready;

  if (PIPE_DEPTH == 1) begin : g_depth1
    assign s1_x1    = in_data;
    assign s1_x2    = x2_in;
    assign s1_x4    = x4_in;
    assign s1_x8    = x8_in;
    assign s1_mode  = in_mode;
    assign s1_valid = in_valid;
    assign in_ready = out_load;
  end else begin : g_depth2
    logic         v1_q;
    logic         ld1;
    logic [W-1:0] x1_q, x2_q, x4_q, x8_q;
    logic [1:0]   mode_q;

    // Stage 1 refills whenever it is empty or its beat moves into the output register.
    assign ld1      = !v1_q || out_load;
    assign in_ready = ld1;

    always_ff @(posedge clk) begin
      if (rst) begin
        v1_q <= 1'b0;
      end else if (ld1) begin
        v1_q <= in_valid;
      end
    end

    always_ff @(posedge clk) begin
      if (ld1 && in_valid) begin
        x1_q   <= in_data;
        x2_q   <= x2_in;
        x4_q   <= x4_in;
        x8_q   <= x8_in;
        mode_q <= in_mode;
      end
    end

    assign s1_x1    = x1_q;
    assign s1_x2    = x2_q;
    assign s1_x4    = x4_q;
    assign s1_x8    = x8_q;
    assign s1_mode  = mode_q;
    assign s1_valid = v1_q;
  end

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    gf_mixcol_col u_col (
      .x1   (s1_x1[W-1-32*c -: 32]),
      .x2   (s1_x2[W-1-32*c -: 32]),
      .x4   (s1_x4[W-1-32*c -: 32]),
      .x8   (s1_x8[W-1-32*c -: 32]),
      .mode (s1_mode),
      .res  (res[W-1-32*c -: 32])
    );
  end

  // Output data only changes when a real beat lands, so it holds through bubbles and stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= MODE_BYP;
    end else if (out_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= res;
        out_mode <= s1_mode;
      end
    end
  end

endmodule

// File: tb/tb_gf_mixcol_pipe.sv
// Directed bench for gf_mixcol_pipe: 4-column/2-stage instance plus a 1-column/1-stage round-trip.
module tb_gf_mixcol_pipe;

  localparam int NC = 4;
  localparam int PD = 2;
  localparam int W  = 32 * NC;
  localparam int RT = 1000;

  localparam logic [W-1:0] V_A   = {4{32'hdb135345}};
  localparam logic [W-1:0] V_AF  = {4{32'h8e4da1bc}};
  localparam logic [W-1:0] V_B   = {4{32'hf20a225c}};
  localparam logic [W-1:0] V_BF  = {4{32'h9fdc589d}};
  localparam logic [W-1:0] V_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [W-1:0] V_MXI = {32'h8e4da1bc, 32'h9fdc589d, 32'hc6c6c6c6, 32'h01010101};
  localparam logic [W-1:0] V_MXO = {32'hdb135345, 32'hf20a225c, 32'hc6c6c6c6, 32'h01010101};

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [1:0]   in_mode, out_mode;
  logic [W-1:0] in_data, out_data;

  logic         r_in_valid, r_in_ready, r_out_valid, r_out_ready;
  logic [1:0]   r_in_mode, r_out_mode;
  logic [31:0]  r_in_data, r_out_data;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] tb_in[6], tb_exp[6];
  logic [1:0]   tb_mode[6];
  logic [31:0]  rt_orig[RT], rt_src[RT], rt_dst[RT];

  always #5 clk = ~clk;

  gf_mixcol_pipe #(.NUM_COLS(NC), .PIPE_DEPTH(PD)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mode  (out_mode),
    .out_data  (out_data)
  );

  gf_mixcol_pipe #(.NUM_COLS(1), .PIPE_DEPTH(1)) dut_small (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (r_in_valid),
    .in_ready  (r_in_ready),
    .in_mode   (r_in_mode),
    .in_data   (r_in_data),
    .out_valid (r_out_valid),
    .out_ready (r_out_ready),
    .out_mode  (r_out_mode),
    .out_data  (r_out_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push one beat with out_ready=1 and return what emerged and how many cycles it took.
  task automatic xfer(input logic [1:0] m, input logic [W-1:0] d,
                      output logic [W-1:0] od, output logic [1:0] om, output int lat);
    int g;
    in_valid = 1'b1; in_mode = m; in_data = d; out_ready = 1'b1; g = 0;
    #1;
    while (!in_ready && g < 20) begin step(); g++; end
    step();
    lat = 1;
    in_valid = 1'b0; in_mode = 2'b00; in_data = '0;
    while (!out_valid && lat < 20) begin step(); lat++; end
    od = out_data; om = out_mode;
    step();
  endtask

  task automatic r_stream(input logic [1:0] m, output int got, output int first);
    got = 0; first = -1; r_out_ready = 1'b1;
    for (int c = 0; c < RT + 20 && got < RT; c++) begin
      r_in_valid = (c < RT);
      r_in_mode  = m;
      r_in_data  = (c < RT) ? rt_src[c] : 32'h0;
      #1;
      if (r_out_valid) begin
        if (first < 0) first = c;
        rt_dst[got] = r_out_data;
        got++;
      end
      step();
    end
    r_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_mode = 2'b00; in_data = '0; out_ready = 1'b0;
    r_in_valid = 1'b0; r_in_mode = 2'b00; r_in_data = '0; r_out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    checks++; if (out_mode !== 2'b00) begin errors++; $display("FAIL reset_out_mode: got %b want 00", out_mode); end
    checks++; if (r_out_valid !== 1'b0) begin errors++; $display("FAIL reset_small_valid: got %b want 0", r_out_valid); end
  endtask

  task automatic test_fwd();
    logic [W-1:0] od; logic [1:0] om; int lat;
    xfer(2'b01, V_A, od, om, lat);
    checks++; if (od !== V_AF) begin errors++; $display("FAIL fwd_data: got %h want %h", od, V_AF); end
    checks++; if (om !== 2'b01) begin errors++; $display("FAIL fwd_mode: got %b want 01", om); end
    checks++; if (lat !== PD) begin errors++; $display("FAIL fwd_latency: got %0d want %0d", lat, PD); end
    xfer(2'b01, V_MXO, od, om, lat);
    checks++; if (od !== V_MXI) begin errors++; $display("FAIL fwd_mixed_cols: got %h want %h", od, V_MXI); end
  endtask

  task automatic test_inv();
    logic [W-1:0] od; logic [1:0] om; int lat;
    xfer(2'b10, V_AF, od, om, lat);
    checks++; if (od !== V_A) begin errors++; $display("FAIL inv_a: got %h want %h", od, V_A); end
    checks++; if (om !== 2'b10) begin errors++; $display("FAIL inv_mode: got %b want 10", om); end
    xfer(2'b10, V_BF, od, om, lat);
    checks++; if (od !== V_B) begin errors++; $display("FAIL inv_b: got %h want %h", od, V_B); end
    xfer(2'b10, V_MXI, od, om, lat);
    checks++; if (od !== V_MXO) begin errors++; $display("FAIL inv_mixed_cols: got %h want %h", od, V_MXO); end
  endtask

  task automatic test_fixed_points();
    logic [W-1:0] od; logic [1:0] om; int lat;
    logic [W-1:0] fp[2];
    fp[0] = {4{32'hc6c6c6c6}};
    fp[1] = {4{32'h01010101}};
    for (int i = 0; i < 2; i++) begin
      xfer(2'b01, fp[i], od, om, lat);
      checks++; if (od !== fp[i]) begin errors++; $display("FAIL fixed_fwd_%0d: got %h want %h", i, od, fp[i]); end
      xfer(2'b10, fp[i], od, om, lat);
      checks++; if (od !== fp[i]) begin errors++; $display("FAIL fixed_inv_%0d: got %h want %h", i, od, fp[i]); end
    end
    xfer(2'b00, V_C, od, om, lat);
    checks++; if (od !== V_C) begin errors++; $display("FAIL bypass_data: got %h want %h", od, V_C); end
    xfer(2'b11, V_A, od, om, lat);
    checks++; if (od !== V_A) begin errors++; $display("FAIL mode11_data: got %h want %h", od, V_A); end
    checks++; if (om !== 2'b11) begin errors++; $display("FAIL mode11_mode: got %b want 11", om); end
  endtask

  task automatic test_back_to_back();
    int ini, outi, first, last;
    bit fire_in;
    ini = 0; outi = 0; first = -1; last = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 50 && outi < 6; cyc++) begin
      in_valid = (ini < 6);
      in_mode  = (ini < 6) ? tb_mode[ini] : 2'b00;
      in_data  = (ini < 6) ? tb_in[ini] : '0;
      #1;
      fire_in = in_valid && in_ready;
      if (out_valid) begin
        checks++;
        if (out_data !== tb_exp[outi]) begin
          errors++; $display("FAIL b2b_data_%0d: got %h want %h", outi, out_data, tb_exp[outi]);
        end
        checks++;
        if (out_mode !== tb_mode[outi]) begin
          errors++; $display("FAIL b2b_mode_%0d: got %b want %b", outi, out_mode, tb_mode[outi]);
        end
        if (first < 0) first = cyc;
        last = cyc;
        outi++;
      end
      step();
      if (fire_in) ini++;
    end
    in_valid = 1'b0;
    checks++; if (outi !== 6) begin errors++; $display("FAIL b2b_count: got %0d want 6", outi); end
    checks++; if (last - first !== 5) begin errors++; $display("FAIL b2b_span: got %0d want 5", last - first); end
    checks++; if (first !== PD) begin errors++; $display("FAIL b2b_first: got %0d want %0d", first, PD); end
  endtask

  task automatic test_stall();
    int ini, outi;
    bit fire_in, fire_out, prev_stall;
    logic [W-1:0] prev_data;
    logic [1:0] prev_mode;
    ini = 0; outi = 0; prev_stall = 1'b0; prev_data = '0; prev_mode = 2'b00;
    for (int cyc = 0; cyc < 400 && outi < 12; cyc++) begin
      out_ready = (cyc < 8) ? 1'b0 : 1'($urandom_range(0, 1));
      in_valid  = (ini < 12);
      in_mode   = tb_mode[ini % 6];
      in_data   = tb_in[ini % 6];
      #1;
      if (cyc >= 2 && cyc < 8) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_full_ready_c%0d: got %b want 0", cyc, in_ready); end
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data || out_mode !== prev_mode) begin
          errors++;
          $display("FAIL stall_hold_c%0d: got v=%b %h/%b want v=1 %h/%b",
                   cyc, out_valid, out_data, out_mode, prev_data, prev_mode);
        end
      end
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        checks++;
        if (out_data !== tb_exp[outi % 6] || out_mode !== tb_mode[outi % 6]) begin
          errors++;
          $display("FAIL stall_beat_%0d: got %h/%b want %h/%b",
                   outi, out_data, out_mode, tb_exp[outi % 6], tb_mode[outi % 6]);
        end
        outi++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_mode  = out_mode;
      step();
      if (fire_in) ini++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (outi !== 12) begin errors++; $display("FAIL stall_out_count: got %0d want 12", outi); end
    checks++; if (ini !== outi) begin errors++; $display("FAIL stall_in_vs_out: got %0d accepted want %0d", ini, outi); end
    step(); step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_no_dup: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    logic [W-1:0] od; logic [1:0] om; int lat;
    int seen;
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'b01; in_data = V_A;
    step(); step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL midrst_data: got %h want 0", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
    out_ready = 1'b1; seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_stale: got %0d beats want 0", seen); end
    xfer(2'b01, V_B, od, om, lat);
    checks++; if (od !== V_BF) begin errors++; $display("FAIL midrst_after: got %h want %h", od, V_BF); end
  endtask

  task automatic test_roundtrip();
    int got, first;
    for (int i = 0; i < RT; i++) begin
      rt_orig[i] = $urandom;
      rt_src[i]  = rt_orig[i];
    end
    r_stream(2'b10, got, first);
    checks++; if (got !== RT) begin errors++; $display("FAIL rt_inv_count: got %0d want %0d", got, RT); end
    checks++; if (first !== 1) begin errors++; $display("FAIL rt_latency: got %0d want 1", first); end
    for (int i = 0; i < RT; i++) rt_src[i] = rt_dst[i];
    r_stream(2'b01, got, first);
    checks++; if (got !== RT) begin errors++; $display("FAIL rt_fwd_count: got %0d want %0d", got, RT); end
    for (int i = 0; i < RT; i++) begin
      checks++;
      if (rt_dst[i] !== rt_orig[i]) begin
        errors++; $display("FAIL rt_col_%0d: got %h want %h", i, rt_dst[i], rt_orig[i]);
      end
    end
  endtask

  initial begin
    tb_mode[0] = 2'b01; tb_in[0] = V_A;  tb_exp[0] = V_AF;
    tb_mode[1] = 2'b10; tb_in[1] = V_BF; tb_exp[1] = V_B;
    tb_mode[2] = 2'b00; tb_in[2] = V_C;  tb_exp[2] = V_C;
    tb_mode[3] = 2'b01; tb_in[3] = V_B;  tb_exp[3] = V_BF;
    tb_mode[4] = 2'b10; tb_in[4] = V_AF; tb_exp[4] = V_A;
    tb_mode[5] = 2'b11; tb_in[5] = V_C;  tb_exp[5] = V_C;
    test_reset();
    test_fwd();
    test_inv();
    test_fixed_points();
    test_back_to_back();
    test_stall();
    test_reset_midstream();
    test_roundtrip();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
